// File: rtl/rv_pkg.sv
// Shared definitions for the program-counter unit: default widths and reset
// vector, the PC FSM state type, and the fetch-address alignment check.
package rv_pkg;

    localparam int              XLEN_DEF         = 32;
    localparam logic [31:0]     RESET_VECTOR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    // True when any of the low align_bits bits of addr is set.
    function automatic logic is_misaligned(input logic [63:0] addr,
                                           input int unsigned align_bits);
        logic [63:0] mask;
        mask = (64'd1 << align_bits) - 64'd1;
        return |(addr & mask);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC helper for pc_unit: sequential PC, redirect target
// (JALR bit-0 clear) and the target alignment flag.
// With PC_UNIT_COMPRESSED_EN defined, the sequential step is 2 for compressed
// instructions and only bit 0 of the target must be clear.
module pc_next_sel
    import rv_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int INC        = 4,
    parameter int ALIGN_BITS = 2
) (
`ifdef PC_UNIT_COMPRESSED_EN
    input  logic            i_is_compressed,
`endif
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_redirect_jalr,
    input  logic [XLEN-1:0] i_redirect_target,
    output logic [XLEN-1:0] o_seq_pc,
    output logic [XLEN-1:0] o_tgt,
    output logic            o_tgt_misaligned
);

`ifdef PC_UNIT_COMPRESSED_EN
    localparam int unsigned CHECK_BITS = 1;
`else
    localparam int unsigned CHECK_BITS = ALIGN_BITS;
`endif

    logic [XLEN-1:0] w_inc;

`ifdef PC_UNIT_COMPRESSED_EN
    assign w_inc = i_is_compressed ? XLEN'(2) : XLEN'(INC);
`else
    assign w_inc = XLEN'(INC);
`endif

    // Sequential address wraps modulo 2^XLEN by plain truncation.
    assign o_seq_pc = i_pc + w_inc;

    // JALR targets always have bit 0 forced low before the alignment check.
    assign o_tgt = i_redirect_jalr ? {i_redirect_target[XLEN-1:1], 1'b0}
                                   : i_redirect_target;

    assign o_tgt_misaligned = is_misaligned(64'(o_tgt), CHECK_BITS);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: architectural PC register with BOOT/RUN/HALT control,
// sequential advance, redirect, stall and halt handling, link value output and
// misaligned-redirect reporting.
// Optional feature macro: PC_UNIT_COMPRESSED_EN (adds is_compressed input).
module pc_unit
    import rv_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int              INC          = 4,
    parameter int              ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic            redirect_jalr,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt_req,
    input  logic            resume,
`ifdef PC_UNIT_COMPRESSED_EN
    input  logic            is_compressed,
`endif
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_addr,
    output logic            halted
);

    pc_state_t       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_misalign_err;
    logic [XLEN-1:0] r_misalign_addr;

    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_tgt;
    logic            w_tgt_misaligned;

    pc_next_sel #(
        .XLEN       (XLEN),
        .INC        (INC),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_next_sel (
`ifdef PC_UNIT_COMPRESSED_EN
        .i_is_compressed   (is_compressed),
`endif
        .i_pc              (r_pc),
        .i_redirect_jalr   (redirect_jalr),
        .i_redirect_target (redirect_target),
        .o_seq_pc          (w_seq_pc),
        .o_tgt             (w_tgt),
        .o_tgt_misaligned  (w_tgt_misaligned)
    );

    // PC FSM: reset, boot bubble, run-time next-PC priority, halt/resume.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from the
        // same pre-edge values regardless of statement order.
        if (rst) begin
            r_state         <= BOOT;
            r_pc            <= RESET_VECTOR;
            r_misalign_err  <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign_err <= 1'b0;
            case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (halt_req) begin
                        r_state <= HALT;
                    end else if (redirect_valid) begin
                        if (!w_tgt_misaligned) begin
                            r_pc <= w_tgt;
                        end else begin
                            r_misalign_err  <= 1'b1;
                            r_misalign_addr <= w_tgt;
                            r_state         <= HALT;
                        end
                    end else if (!stall) begin
                        r_pc <= w_seq_pc;
                    end
                end
                HALT: begin
                    // A simultaneous halt request wins over resume.
                    if (resume && !halt_req) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    assign pc            = r_pc;
    assign pc_valid      = (r_state == RUN);
    assign halted        = (r_state == HALT);
    assign pc_plus_inc   = w_seq_pc;
    assign misalign_err  = r_misalign_err;
    assign misalign_addr = r_misalign_addr;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: each scenario task drives one cycle of
// stimulus, pushes the expected post-edge outputs, then pops and compares.
module tb_pc_unit;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        rv;
        logic        jalr;
        logic [31:0] tgt;
        logic        hreq;
        logic        res;
        logic        comp;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ppi;
        logic        err;
        logic [31:0] maddr;
        logic        halted;
    } obs_t;

`ifdef PC_UNIT_COMPRESSED_EN
    localparam logic [31:0] MIS_TGT = 32'h0000_0203;
`else
    localparam logic [31:0] MIS_TGT = 32'h0000_0202;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, redirect_jalr, halt_req, resume;
    logic        is_compressed;
    logic [31:0] redirect_target;
    logic [31:0] pc, pc_plus_inc, misalign_addr;
    logic        pc_valid, misalign_err, halted;

    int checks = 0;
    int errors = 0;
    obs_t sb[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_jalr   (redirect_jalr),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .resume          (resume),
`ifdef PC_UNIT_COMPRESSED_EN
        .is_compressed   (is_compressed),
`endif
        .pc              (pc),
        .pc_valid        (pc_valid),
        .pc_plus_inc     (pc_plus_inc),
        .misalign_err    (misalign_err),
        .misalign_addr   (misalign_addr),
        .halted          (halted)
    );

    function automatic stim_t mk(logic r, logic st, logic rv, logic j,
                                 logic [31:0] t, logic hr, logic rs, logic c);
        stim_t s;
        s = '{rst: r, stall: st, rv: rv, jalr: j, tgt: t, hreq: hr, res: rs, comp: c};
        return s;
    endfunction

    // Expected outputs; the link value follows the step selected by is_compressed.
    function automatic obs_t ex(logic [31:0] p, logic v, logic e,
                                logic [31:0] ma, logic h, logic c);
        obs_t o;
        logic [31:0] step;
        step = c ? 32'd2 : 32'd4;
        o = '{pc: p, valid: v, ppi: p + step, err: e, maddr: ma, halted: h};
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{pc: pc, valid: pc_valid, ppi: pc_plus_inc, err: misalign_err,
              maddr: misalign_addr, halted: halted};
        return o;
    endfunction

    task automatic drive(input stim_t s);
        rst             = s.rst;
        stall           = s.stall;
        redirect_valid  = s.rv;
        redirect_jalr   = s.jalr;
        redirect_target = s.tgt;
        halt_req        = s.hreq;
        resume          = s.res;
        is_compressed   = s.comp;
    endtask

    task automatic test_reset();
        stim_t st[$];
        obs_t  xp[$];
        obs_t  e, o;
        st.push_back(mk(1, 0, 0, 0, 32'h0, 0, 0, 0)); xp.push_back(ex(32'h0, 0, 0, 32'h0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]); sb.push_back(xp[i]);
            @(posedge clk); @(negedge clk);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d] got pc=%h v=%b ppi=%h err=%b ma=%h h=%b want pc=%h v=%b ppi=%h err=%b ma=%h h=%b",
                         i, o.pc, o.valid, o.ppi, o.err, o.maddr, o.halted, e.pc, e.valid, e.ppi, e.err, e.maddr, e.halted);
            end
        end
    endtask

    task automatic test_sequential();
        stim_t st[$];
        obs_t  xp[$];
        obs_t  e, o;
        st.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0)); xp.push_back(ex(32'h0, 1, 0, 32'h0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0)); xp.push_back(ex(32'h4, 1, 0, 32'h0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0)); xp.push_back(ex(32'h8, 1, 0, 32'h0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0)); xp.push_back(ex(32'hC, 1, 0, 32'h0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]); sb.push_back(xp[i]);
            @(posedge clk); @(negedge clk);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sequential[%0d] got pc=%h v=%b ppi=%h err=%b ma=%h h=%b want pc=%h v=%b ppi=%h err=%b ma=%h h=%b",
                         i, o.pc, o.valid, o.ppi, o.err, o.maddr, o.halted, e.pc, e.valid, e.ppi, e.err, e.maddr, e.halted);
            end
        end
    endtask

    task automatic test_stall_redirect();
        stim_t st[$];
        obs_t  xp[$];
        obs_t  e, o;
        st.push_back(mk(0, 0, 1, 0, 32'h8,   0, 0, 0)); xp.push_back(ex(32'h8,   1, 0, 32'h0, 0, 0));
        st.push_back(mk(0, 1, 0, 0, 32'h0,   0, 0, 0)); xp.push_back(ex(32'h8,   1, 0, 32'h0, 0, 0));
        st.push_back(mk(0, 1, 1, 0, 32'h100, 0, 0, 0)); xp.push_back(ex(32'h100, 1, 0, 32'h0, 0, 0));
        st.push_back(mk(0, 1, 0, 0, 32'h0,   0, 0, 0)); xp.push_back(ex(32'h100, 1, 0, 32'h0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0)); xp.push_back(ex(32'h104, 1, 0, 32'h0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]); sb.push_back(xp[i]);
            @(posedge clk); @(negedge clk);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall_redirect[%0d] got pc=%h v=%b ppi=%h err=%b ma=%h h=%b want pc=%h v=%b ppi=%h err=%b ma=%h h=%b",
                         i, o.pc, o.valid, o.ppi, o.err, o.maddr, o.halted, e.pc, e.valid, e.ppi, e.err, e.maddr, e.halted);
            end
        end
    endtask

    task automatic test_jalr_misalign();
        stim_t st[$];
        obs_t  xp[$];
        obs_t  e, o;
        st.push_back(mk(0, 0, 1, 1, 32'h201, 0, 0, 0)); xp.push_back(ex(32'h200, 1, 0, 32'h0,   0, 0));
        st.push_back(mk(0, 0, 1, 0, MIS_TGT, 0, 0, 0)); xp.push_back(ex(32'h200, 0, 1, MIS_TGT, 1, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0)); xp.push_back(ex(32'h200, 0, 0, MIS_TGT, 1, 0));
        st.push_back(mk(0, 1, 1, 0, 32'h400, 0, 0, 0)); xp.push_back(ex(32'h200, 0, 0, MIS_TGT, 1, 0));
        foreach (st[i]) begin
            drive(st[i]); sb.push_back(xp[i]);
            @(posedge clk); @(negedge clk);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL jalr_misalign[%0d] got pc=%h v=%b ppi=%h err=%b ma=%h h=%b want pc=%h v=%b ppi=%h err=%b ma=%h h=%b",
                         i, o.pc, o.valid, o.ppi, o.err, o.maddr, o.halted, e.pc, e.valid, e.ppi, e.err, e.maddr, e.halted);
            end
        end
    endtask

    task automatic test_halt_resume();
        stim_t st[$];
        obs_t  xp[$];
        obs_t  e, o;
        st.push_back(mk(0, 0, 0, 0, 32'h0,   1, 1, 0)); xp.push_back(ex(32'h200, 0, 0, MIS_TGT, 1, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0,   0, 1, 0)); xp.push_back(ex(32'h200, 1, 0, MIS_TGT, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0)); xp.push_back(ex(32'h204, 1, 0, MIS_TGT, 0, 0));
        st.push_back(mk(0, 0, 1, 0, 32'h300, 1, 0, 0)); xp.push_back(ex(32'h204, 0, 0, MIS_TGT, 1, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0,   0, 1, 0)); xp.push_back(ex(32'h204, 1, 0, MIS_TGT, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0)); xp.push_back(ex(32'h208, 1, 0, MIS_TGT, 0, 0));
        foreach (st[i]) begin
            drive(st[i]); sb.push_back(xp[i]);
            @(posedge clk); @(negedge clk);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL halt_resume[%0d] got pc=%h v=%b ppi=%h err=%b ma=%h h=%b want pc=%h v=%b ppi=%h err=%b ma=%h h=%b",
                         i, o.pc, o.valid, o.ppi, o.err, o.maddr, o.halted, e.pc, e.valid, e.ppi, e.err, e.maddr, e.halted);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t st[$];
        obs_t  xp[$];
        obs_t  e, o;
        st.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFFC, 0, 0, 0)); xp.push_back(ex(32'hFFFF_FFFC, 1, 0, MIS_TGT, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 0)); xp.push_back(ex(32'h0,         1, 0, MIS_TGT, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 0)); xp.push_back(ex(32'h4,         1, 0, MIS_TGT, 0, 0));
        foreach (st[i]) begin
            drive(st[i]); sb.push_back(xp[i]);
            @(posedge clk); @(negedge clk);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wrap[%0d] got pc=%h v=%b ppi=%h err=%b ma=%h h=%b want pc=%h v=%b ppi=%h err=%b ma=%h h=%b",
                         i, o.pc, o.valid, o.ppi, o.err, o.maddr, o.halted, e.pc, e.valid, e.ppi, e.err, e.maddr, e.halted);
            end
        end
    endtask

    task automatic test_reset_midrun();
        stim_t st[$];
        obs_t  xp[$];
        obs_t  e, o;
        st.push_back(mk(0, 0, 1, 0, 32'h40, 0, 0, 0)); xp.push_back(ex(32'h40, 1, 0, MIS_TGT, 0, 0));
        st.push_back(mk(1, 0, 1, 0, 32'h83, 0, 0, 0)); xp.push_back(ex(32'h0,  0, 0, 32'h0,   0, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0,  0, 0, 0)); xp.push_back(ex(32'h0,  1, 0, 32'h0,   0, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0,  0, 0, 0)); xp.push_back(ex(32'h4,  1, 0, 32'h0,   0, 0));
        foreach (st[i]) begin
            drive(st[i]); sb.push_back(xp[i]);
            @(posedge clk); @(negedge clk);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_midrun[%0d] got pc=%h v=%b ppi=%h err=%b ma=%h h=%b want pc=%h v=%b ppi=%h err=%b ma=%h h=%b",
                         i, o.pc, o.valid, o.ppi, o.err, o.maddr, o.halted, e.pc, e.valid, e.ppi, e.err, e.maddr, e.halted);
            end
        end
    endtask

`ifdef PC_UNIT_COMPRESSED_EN
    task automatic test_compressed();
        stim_t st[$];
        obs_t  xp[$];
        obs_t  e, o;
        st.push_back(mk(0, 0, 1, 0, 32'h10, 0, 0, 0)); xp.push_back(ex(32'h10, 1, 0, 32'h0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 32'h0,  0, 0, 1)); xp.push_back(ex(32'h12, 1, 0, 32'h0, 0, 1));
        st.push_back(mk(0, 0, 0, 0, 32'h0,  0, 0, 1)); xp.push_back(ex(32'h14, 1, 0, 32'h0, 0, 1));
        st.push_back(mk(0, 0, 0, 0, 32'h0,  0, 0, 0)); xp.push_back(ex(32'h18, 1, 0, 32'h0, 0, 0));
        st.push_back(mk(0, 0, 1, 0, 32'h22, 0, 0, 0)); xp.push_back(ex(32'h22, 1, 0, 32'h0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]); sb.push_back(xp[i]);
            @(posedge clk); @(negedge clk);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL compressed[%0d] got pc=%h v=%b ppi=%h err=%b ma=%h h=%b want pc=%h v=%b ppi=%h err=%b ma=%h h=%b",
                         i, o.pc, o.valid, o.ppi, o.err, o.maddr, o.halted, e.pc, e.valid, e.ppi, e.err, e.maddr, e.halted);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_jalr_misalign();
        test_halt_resume();
        test_wrap();
        test_reset_midrun();
`ifdef PC_UNIT_COMPRESSED_EN
        test_compressed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule
